cla_add_pipe: RTL
=================

CLA_ADD_PIPE -- requirements
Module: cla_add_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width; multiple of 4, range 8..64.
REQ-002 SHALL have parameter GPS, default 1, 4-bit groups per stage; must divide WIDTH/4.
REQ-003 SHALL have clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have in_valid  input  1  operands valid.
REQ-006 SHALL have in_ready  output  1  block accepts operands this cycle.
REQ-007 SHALL have a  input  WIDTH  operand A, unsigned or two's complement.
REQ-008 SHALL have b  input  WIDTH  operand B.
REQ-009 SHALL have cin  input  1  carry-in; ignored when sub=1.
REQ-010 SHALL have sub  input  1  0 = A+B+cin, 1 = A-B (A + ~B + 1).
REQ-011 SHALL have out_valid  output  1  result valid.
REQ-012 SHALL have out_ready  input  1  downstream accepts result.
REQ-013 SHALL have sum  output  WIDTH  result.
REQ-014 SHALL have cout  output  1  carry out of MSB; for sub, 1 means no borrow.
REQ-015 SHALL have ovf  output  1  signed overflow.
REQ-016 SHALL have ps, gs  output  1 each  whole-word propagate/generate of the effective operands.

Function
REQ-017 SHALL define NSTG = WIDTH/(4*GPS) pipeline stages; latency NSTG cycles, accept to out_valid.
REQ-018 SHALL compute, in stage k, groups k*GPS..k*GPS+GPS-1 from the stage-k-1 registered carry, with 4-bit lookahead inside each group and group-level lookahead (group P/G) across the GPS groups.
REQ-019 SHALL carry unprocessed upper operand bits and finished lower sum bits forward, so each stage register holds exactly one transaction.
REQ-020 SHALL latch effective B (~b when sub) and effective carry-in (1 when sub) at acceptance; later changes to a, b, sub, and cin SHALL NOT affect accepted transactions.
REQ-021 SHALL use advance = !out_valid | out_ready; all stage registers load only when advance=1.
REQ-022 SHALL drive in_ready = advance, combinationally; in_valid & in_ready is a transfer.
REQ-023 SHALL propagate per-stage valid bits; bubbles travel as valid=0 and are not collapsed.
REQ-024 SHALL hold sum, cout, ovf, ps, gs, and out_valid stable while out_valid=1 and out_ready=0.
REQ-025 SHALL sustain 1 transaction/cycle when out_ready stays 1.
REQ-026 SHALL compute ovf = carry into MSB XOR carry out of MSB.
REQ-027 SHALL compute ps as the AND of all group P, and gs as the lookahead combination of all group G/P, independent of cin.
REQ-028 SHALL give a simultaneous output drain and input accept in the same cycle with no loss or duplication.
REQ-029 SHALL ignore in_valid=1 while in_ready=0; the source holds its data.

Reset
REQ-030 SHALL clear all stage valid bits, sum, cout, ovf, ps, gs, and internal carries to 0 on rst=1 at a clock edge.
REQ-031 SHALL discard in-flight transactions on mid-operation reset; out_valid=0 on the cycle after rst.
REQ-032 SHALL drive in_ready=1 during and after reset; no transfer SHALL be accepted in a cycle with rst=1.

Structure
REQ-033 SHALL place group width 4, the NSTG computation function, and the parameter legality checks in shared package cla_pkg.
REQ-034 SHALL instantiate sub-module cla_group4 (4-bit p/g, internal carries, sum, group P/G, group carry-out) once per group.
REQ-035 SHALL reject illegal WIDTH/GPS at elaboration.

Verification
REQ-036 WIDTH=16, GPS=1, a=0xFFFF, b=0x0001, cin=0, sub=0 -> after 4 cycles, sum=0x0000, cout=1, ovf=0, ps=1, gs=1.
REQ-037 WIDTH=16, a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, ovf=1, cout=0; a=0x0003, b=0x0005, sub=1 -> sum=0xFFFE, cout=0, ovf=0.
REQ-038 Back-to-back: 100 random transfers with out_ready=1 -> one result per cycle, in order, matching the reference model.
REQ-039 Backpressure: out_ready=0 for 6 cycles with the pipeline full -> in_ready=0, outputs stable, no loss; release -> all results in order.
REQ-040 Reset asserted with 3 transactions in flight -> out_valid=0 the next cycle, with none of them emerging afterwards.
REQ-041 WIDTH=32, GPS=2 and WIDTH=64, GPS=4 -> latency 4 cycles, random results correct including cin=1.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined carry-lookahead adder.
package cla_pkg;

  localparam int GRP_W = 4;

  function automatic bit cla_params_ok(input int width, input int gps);
    return (width >= 8) && (width <= 64) && (width % GRP_W == 0) &&
           (gps >= 1) && ((width / GRP_W) % gps == 0);
  endfunction

  // Number of pipeline stages; guarded so an illegal GPS cannot divide by zero.
  function automatic int cla_nstg(input int width, input int gps);
    return (gps < 1) ? 1 : width / (GRP_W * gps);
  endfunction

endpackage

// File: rtl/cla_group4.sv
// 4-bit lookahead group: internal carries, sum, group propagate/generate and carry-out.
module cla_group4
  import cla_pkg::*;
(
  input  logic [GRP_W-1:0] a,
  input  logic [GRP_W-1:0] b,
  input  logic             cin,
  output logic [GRP_W-1:0] s,
  output logic             pg,
  output logic             gg,
  output logic             cout,
  output logic             c3
);

  logic [GRP_W-1:0] t;
  logic [GRP_W-1:0] p;
  logic [GRP_W-1:0] g;
  logic             c1;
  logic             c2;

  // Inclusive-OR propagate drives the carries; the XOR half-sum forms the sum bits.
  assign t = a ^ b;
  assign p = a | b;
  assign g = a & b;

  assign c1 = g[0] | (p[0] & cin);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

  assign gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign pg   = &p;
  assign cout = gg | (pg & cin);
  assign s    = t ^ {c3, c2, c1, cin};

endmodule

// File: rtl/cla_add_pipe.sv
// Pipelined carry-lookahead adder/subtractor: GPS 4-bit groups resolved per stage, valid/ready handshake.
module cla_add_pipe
  import cla_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int GPS   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             ps,
  output logic             gs
);

  localparam int NSTG = cla_nstg(WIDTH, GPS);
  localparam int NG   = WIDTH / GRP_W;
  localparam int SW   = GRP_W * GPS;

  if (!cla_params_ok(WIDTH, GPS)) begin : g_bad_params
    $error("cla_add_pipe: WIDTH must be a multiple of 4 in 8..64 and GPS must divide WIDTH/4");
  end

  logic             advance;
  logic [WIDTH-1:0] a_in [NSTG];
  logic [WIDTH-1:0] b_in [NSTG];
  logic [WIDTH-1:0] s_in [NSTG];
  logic             c_in [NSTG];
  logic             p_in [NSTG];
  logic             g_in [NSTG];
  logic             vld_in [NSTG];
  logic [WIDTH-1:0] a_d [NSTG], a_q [NSTG];
  logic [WIDTH-1:0] b_d [NSTG], b_q [NSTG];
  logic [WIDTH-1:0] s_d [NSTG], s_q [NSTG];
  logic             c_d [NSTG], c_q [NSTG];
  logic             p_d [NSTG], p_q [NSTG];
  logic             g_d [NSTG], g_q [NSTG];
  logic             vld_d [NSTG], vld_q [NSTG];
  logic             ovf_d, ovf_q;
  logic [WIDTH-1:0] ga, gb, gsum;
  logic [NG-1:0]    gcin, gp, gg, gco, gc3;
  logic             unused_bits;

  assign advance  = !vld_q[NSTG-1] | out_ready;
  assign in_ready = advance | rst;

  // Stage 0 takes the effective operands straight from the ports; later stages from the previous register.
  always_comb begin
    a_in[0]   = a;
    b_in[0]   = sub ? ~b : b;
    c_in[0]   = sub | cin;
    s_in[0]   = '0;
    p_in[0]   = 1'b1;
    g_in[0]   = 1'b0;
    vld_in[0] = in_valid;
    for (int k = 1; k < NSTG; k++) begin
      a_in[k]   = a_q[k-1];
      b_in[k]   = b_q[k-1];
      c_in[k]   = c_q[k-1];
      s_in[k]   = s_q[k-1];
      p_in[k]   = p_q[k-1];
      g_in[k]   = g_q[k-1];
      vld_in[k] = vld_q[k-1];
    end
  end

  always_comb begin
    ga = '0;
    gb = '0;
    for (int k = 0; k < NSTG; k++) begin
      ga[k*SW +: SW] = a_in[k][k*SW +: SW];
      gb[k*SW +: SW] = b_in[k][k*SW +: SW];
    end
  end

  for (genvar gi = 0; gi < NG; gi++) begin : g_grp
    cla_group4 u_grp (
      .a    (ga[gi*GRP_W +: GRP_W]),
      .b    (gb[gi*GRP_W +: GRP_W]),
      .cin  (gcin[gi]),
      .s    (gsum[gi*GRP_W +: GRP_W]),
      .pg   (gp[gi]),
      .gg   (gg[gi]),
      .cout (gco[gi]),
      .c3   (gc3[gi])
    );
  end

  // Group-level lookahead across the stage's groups, plus the running whole-word P/G.
  always_comb begin
    logic c, sp, sg;
    gcin = '0;
    for (int k = 0; k < NSTG; k++) begin
      c  = c_in[k];
      sp = 1'b1;
      sg = 1'b0;
      for (int j = 0; j < GPS; j++) begin
        gcin[k*GPS+j] = c;
        c  = gg[k*GPS+j] | (gp[k*GPS+j] & c);
        sg = gg[k*GPS+j] | (gp[k*GPS+j] & sg);
        sp = sp & gp[k*GPS+j];
      end
      c_d[k] = c;
      p_d[k] = p_in[k] & sp;
      g_d[k] = sg | (sp & g_in[k]);
    end
  end

  always_comb begin
    for (int k = 0; k < NSTG; k++) begin
      a_d[k]   = a_in[k];
      b_d[k]   = b_in[k];
      vld_d[k] = vld_in[k];
      s_d[k]   = s_in[k];
      s_d[k][k*SW +: SW] = gsum[k*SW +: SW];
    end
    ovf_d = gc3[NG-1] ^ gco[NG-1];
  end

  assign unused_bits = ^{gco[NG-2:0], gc3[NG-2:0], a_q[NSTG-1], b_q[NSTG-1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NSTG; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        s_q[k]   <= '0;
        c_q[k]   <= 1'b0;
        p_q[k]   <= 1'b0;
        g_q[k]   <= 1'b0;
        vld_q[k] <= 1'b0;
      end
      ovf_q <= 1'b0;
    end else if (advance) begin
      for (int k = 0; k < NSTG; k++) begin
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
        s_q[k]   <= s_d[k];
        c_q[k]   <= c_d[k];
        p_q[k]   <= p_d[k];
        g_q[k]   <= g_d[k];
        vld_q[k] <= vld_d[k];
      end
      ovf_q <= ovf_d;
    end
  end

  assign out_valid = vld_q[NSTG-1];
  assign sum       = s_q[NSTG-1];
  assign cout      = c_q[NSTG-1];
  assign ovf       = ovf_q;
  assign ps        = p_q[NSTG-1];
  assign gs        = g_q[NSTG-1];

endmodule
